// File: rtl/svreal_mac_acc.sv
// svreal_mac_acc: framed fixed-point multiply-accumulate, LEN samples per frame.
// Ports: clk_ext, rst_ext (async, high), ce_ext; in_valid/in_ready, a_in, b_in;
//        out_valid/out_ready, out_o (exponent EXP_O), ovf_o (frame overflow).
// Macro SVREAL_MAC_SAT_EN: saturate out-of-range results instead of wrapping.
module svreal_mac_acc #(
   parameter int WIDTH_A = 16,
   parameter int EXP_A   = -8,
   parameter int WIDTH_B = 17,
   parameter int EXP_B   = -9,
   parameter int WIDTH_O = 18,
   parameter int EXP_O   = -10,
   parameter int LEN     = 8
) (
   input  logic                      clk_ext,
   input  logic                      rst_ext,
   input  logic                      ce_ext,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [WIDTH_A-1:0] a_in,
   input  logic signed [WIDTH_B-1:0] b_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [WIDTH_O-1:0] out_o,
   output logic                      ovf_o
);

   localparam int PW  = WIDTH_A + WIDTH_B;
   localparam int CW  = $clog2(LEN);
   localparam int AW  = PW + CW;
   localparam int SH  = EXP_O - (EXP_A + EXP_B);
   localparam int NSH = (SH < 0) ? -SH : 0;
   localparam int SW  = AW + NSH;

   typedef enum logic [1:0] {ACCUM, FLUSH, DONE} state_t;

   state_t state, state_nxt;

   logic                 accept;
   logic                 flush_end;
   logic                 out_take;
   logic                 last;
   logic [CW-1:0]        cnt;
   logic signed [PW-1:0] prod;
   logic                 pvalid;
   logic signed [AW-1:0] acc;
   logic signed [SW-1:0] shv;
   logic signed [WIDTH_O-1:0] fit;
   logic                 ovf;

   assign last = (cnt == CW'(LEN - 1));

   always_ff @(posedge clk_ext or posedge rst_ext) begin
      if (rst_ext) begin
         state <= ACCUM;
      end else if (ce_ext) begin
         state <= state_nxt;
      end
   end

   // FLUSH waits until the final product has been folded into acc,
   // so the result register is loaded from a complete sum.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      flush_end = 1'b0;
      out_take  = 1'b0;
      unique case (state)
         ACCUM: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (in_valid && last) begin
               state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            if (!pvalid) begin
               flush_end = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               out_take  = 1'b1;
               state_nxt = ACCUM;
            end
         end
         default: state_nxt = ACCUM;
      endcase
   end

   always_ff @(posedge clk_ext or posedge rst_ext) begin
      if (rst_ext) begin
         cnt    <= '0;
         prod   <= '0;
         pvalid <= 1'b0;
         acc    <= '0;
         out_o  <= '0;
         ovf_o  <= 1'b0;
      end else if (ce_ext) begin
         pvalid <= accept;
         if (accept) begin
            prod <= PW'(a_in) * PW'(b_in);
            cnt  <= last ? '0 : cnt + CW'(1);
         end
         if (out_take) begin
            acc <= '0;
         end else if (pvalid) begin
            acc <= acc + AW'(prod);
         end
         if (flush_end) begin
            out_o <= fit;
            ovf_o <= ovf;
         end
      end
   end

   // Align the accumulator to the output exponent. A right shift floors;
   // a left shift widens so no bits are lost before the range check.
   generate
      if (SH >= 0) begin : g_rsh
         assign shv = acc >>> SH;
      end else begin : g_lsh
         assign shv = {acc, {NSH{1'b0}}};
      end
   endgenerate

   // In range iff all bits from the output sign bit upward agree.
   generate
      if (SW > WIDTH_O) begin : g_fit
         logic [SW-WIDTH_O:0] hi;
         assign hi  = shv[SW-1:WIDTH_O-1];
         assign ovf = !((&hi) || !(|hi));
`ifdef SVREAL_MAC_SAT_EN
         localparam logic signed [WIDTH_O-1:0] MAXV = {1'b0, {(WIDTH_O-1){1'b1}}};
         localparam logic signed [WIDTH_O-1:0] MINV = {1'b1, {(WIDTH_O-1){1'b0}}};
         assign fit = ovf ? (shv[SW-1] ? MINV : MAXV) : shv[WIDTH_O-1:0];
`else
         assign fit = shv[WIDTH_O-1:0];
`endif
      end else begin : g_ext
         assign ovf = 1'b0;
         assign fit = WIDTH_O'(shv);
      end
   endgenerate

endmodule

// File: doc/svreal_mac_acc.md
SVREAL_MAC_ACC -- requirements
Module: svreal_mac_acc

Interface
REQ-001 Parameters SHALL be (name, default, meaning): WIDTH_A, 16, a significand width; EXP_A, -8, a exponent; WIDTH_B, 17, b significand width; EXP_B, -9, b exponent; WIDTH_O, 18, result significand width; EXP_O, -10, result exponent; LEN, 8, samples per frame (>=2).
REQ-002 clk_ext  in  1  single clock; all state updates on rising edge.
REQ-003 rst_ext  in  1  asynchronous, active-high reset.
REQ-004 ce_ext  in  1  clock enable; low freezes every register and state, including the handshake outputs.
REQ-005 in_valid  in  1 / in_ready  out  1  input handshake.
REQ-006 a_in  in  WIDTH_A  signed significand (EXP_A); b_in  in  WIDTH_B  signed significand (EXP_B).
REQ-007 out_valid  out  1 / out_ready  in  1  output handshake.
REQ-008 out_o  out  WIDTH_O  signed result significand (EXP_O); ovf_o  out  1  frame overflow flag.

Function
REQ-009 Sample SHALL be accepted when in_valid && in_ready && ce_ext.
REQ-010 Stage 1 SHALL register full-precision product a_in*b_in (WIDTH_A+WIDTH_B bits, exponent EXP_A+EXP_B) with a product-valid bit.
REQ-011 Stage 2 SHALL add a valid registered product into accumulator of WIDTH_A+WIDTH_B+clog2(LEN) bits, exponent EXP_A+EXP_B; no internal overflow possible.
REQ-012 FSM states SHALL be ACCUM, FLUSH, DONE; reset state ACCUM.
REQ-013 ACCUM: in_ready=1; sample counter increments per accepted sample; acceptance of the LEN-th sample -> FLUSH, counter -> 0.
REQ-014 FLUSH: in_ready=0; after the last product enters the accumulator -> DONE, out_o/ovf_o registered, out_valid=1.
REQ-015 Result latency SHALL be 2 enabled cycles after acceptance of the LEN-th sample.
REQ-016 Result conversion SHALL shift the accumulator by EXP_O-(EXP_A+EXP_B) (arithmetic right shift truncating toward negative infinity when positive, left shift when negative), then fit to WIDTH_O per REQ-024.
REQ-017 DONE: in_ready=0; out_o, ovf_o held stable while out_valid && !out_ready.
REQ-018 DONE with out_ready && ce_ext -> ACCUM, accumulator cleared, out_valid=0 next cycle; in_ready=1 next cycle (no same-cycle input acceptance).
REQ-019 ovf_o SHALL be 1 iff the shifted result is outside signed WIDTH_O range; recomputed per frame.
REQ-020 in_valid during FLUSH/DONE SHALL have no effect; a_in/b_in ignored when not accepted.

Reset
REQ-021 rst_ext assertion SHALL immediately force state ACCUM, counter 0, accumulator 0, product-valid 0, out_valid 0, out_o 0, ovf_o 0, regardless of ce_ext or clk_ext.
REQ-022 Reset mid-frame SHALL discard all partial accumulation; the first post-reset accepted sample starts a new frame.
REQ-023 in_ready SHALL be 1 during and after reset (state ACCUM).

Configuration
REQ-024 Macro SVREAL_MAC_SAT_EN: defined -> out-of-range results saturate to +2^(WIDTH_O-1)-1 or -2^(WIDTH_O-1); undefined -> low WIDTH_O bits kept (two's-complement wrap). ovf_o behaves identically in both builds.

Verification
REQ-025 LEN=8, eight samples a=256 (1.0), b=512 (1.0), out_ready=1 -> out_o=8192 (8.0), ovf_o=0, out_valid exactly 2 cycles after the 8th acceptance.
REQ-026 Sample a=-1, b=1, then seven zeros -> out_o=-1 (floor truncation), ovf_o=0.
REQ-027 Eight samples a=32767, b=65535 -> ovf_o=1; out_o=131071 with SVREAL_MAC_SAT_EN, out_o=-6144 without.
REQ-028 out_ready held 0 for 5 cycles after out_valid -> out_o, ovf_o, out_valid stable; in_ready=0; in_valid pulses ignored; on out_ready=1 next frame of ones yields 8192.
REQ-029 rst_ext pulsed asynchronously after 3 accepted samples -> outputs zero immediately, in_ready=1; next 8 samples of ones -> out_o=8192.
REQ-030 ce_ext=0 for 3 cycles mid-frame with in_valid=1 -> no acceptance, no state change; final result equals unstalled result.
